// File: rtl/bt_update_queue_pkg.sv
// Shared core types for the branch-target update path: the BTB update record,
// fetch offset type, default queue sizing and the bubble FSM state encoding.
package bt_update_queue_pkg;

  typedef logic [2:0] FetchOff_t;

  typedef struct packed {
    logic        valid;
    logic        clean;
    logic        multiple;
    FetchOff_t   fetchStartOffs;
    logic [31:0] src;
    logic [31:0] dst;
  } BTUpdate;

  localparam int BT_QUEUE_DEPTH = 8;
  localparam int BT_NUM_PORTS   = 2;

  typedef enum logic {
    ST_ISSUE = 1'b0,
    ST_HOLD  = 1'b1
  } bubble_state_e;

  // Two updates describe the same BTB write when src, dst and multiple agree.
  function automatic logic same_target(input BTUpdate a, input BTUpdate b);
    return (a.src == b.src) && (a.dst == b.dst) && (a.multiple == b.multiple);
  endfunction

endpackage

// File: rtl/bt_update_queue_if.sv
// Bundle of resolved-branch inputs, flush and BTB-facing outputs of the update queue.
interface bt_update_queue_if
  import bt_update_queue_pkg::*;
#(
  parameter int NUM_PORTS = BT_NUM_PORTS
);

  BTUpdate [NUM_PORTS-1:0] IN_res;
  logic                    IN_flush;
  BTUpdate                 OUT_btUpdate;
  logic [15:0]             OUT_dropCnt;
  logic                    OUT_empty;

  modport master (
    output IN_res,
    output IN_flush,
    input  OUT_btUpdate,
    input  OUT_dropCnt,
    input  OUT_empty
  );

  modport slave (
    input  IN_res,
    input  IN_flush,
    output OUT_btUpdate,
    output OUT_dropCnt,
    output OUT_empty
  );

endinterface

// File: rtl/bt_update_fifo.sv
// Circular FIFO of BTB updates with extra-MSB pointers; accepts a compacted
// burst of pushes per cycle and can hand the first push straight through when empty.
module bt_update_fifo
  import bt_update_queue_pkg::*;
#(
  parameter int  DEPTH     = BT_QUEUE_DEPTH,
  parameter int  NUM_PORTS = BT_NUM_PORTS,
  localparam int AW        = $clog2(DEPTH),
  localparam int CW        = $clog2(NUM_PORTS + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_flush,
  input  logic [CW-1:0]           i_push_cnt,
  input  BTUpdate [NUM_PORTS-1:0] i_push_data,
  input  logic                    i_pop,
  output logic                    o_pop_vld,
  output BTUpdate                 o_pop_data,
  output logic [AW:0]             o_free_cnt,
  output BTUpdate                 o_newest,
  output logic                    o_empty
);

  logic [AW:0]   r_wptr;
  logic [AW:0]   r_rptr;
  BTUpdate       r_mem [DEPTH];

  logic [AW:0]   w_count;
  logic          w_empty;
  logic          w_full;
  logic [AW:0]   w_free_base;
  logic          w_pop_store;
  logic [AW-1:0] w_last;

  assign w_count     = r_wptr - r_rptr;
  assign w_empty     = (r_wptr == r_rptr);
  assign w_full      = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_free_base = w_full ? '0 : ((AW+1)'(DEPTH) - w_count);

  // A pop from storage frees its slot before this cycle's pushes are placed.
  assign w_pop_store = i_pop && !w_empty;
  assign o_free_cnt  = w_free_base + (AW+1)'(w_pop_store);

  // When empty, the first pushed entry is written and consumed in the same edge.
  assign o_pop_vld   = i_pop && (!w_empty || (i_push_cnt != '0));
  assign o_pop_data  = w_empty ? i_push_data[0] : r_mem[r_rptr[AW-1:0]];

  assign w_last      = r_wptr[AW-1:0] - AW'(1);
  assign o_newest    = r_mem[w_last];
  assign o_empty     = w_empty;

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      r_wptr <= r_wptr + (AW+1)'(i_push_cnt);
      if (o_pop_vld) begin
        r_rptr <= r_rptr + (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (CW'(p) < i_push_cnt) begin
        r_mem[r_wptr[AW-1:0] + AW'(p)] <= i_push_data[p];
      end
    end
  end

endmodule

// File: rtl/bt_update_queue.sv
// Buffers resolved-branch BTB updates: dedups and orders multi-port requests,
// counts drops on overflow, and issues one registered update per cycle with a
// bubble after every multiple-bit update.
module bt_update_queue
  import bt_update_queue_pkg::*;
#(
  parameter int  QUEUE_DEPTH = BT_QUEUE_DEPTH,
  parameter int  NUM_PORTS   = BT_NUM_PORTS,
  localparam int AW          = $clog2(QUEUE_DEPTH),
  localparam int CW          = $clog2(NUM_PORTS + 1)
) (
  input  logic            clk,
  input  logic            rst,
  bt_update_queue_if.slave bus
);

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [CW-1:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + 17'(b);
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  bubble_state_e           r_state;
  bubble_state_e           w_state_nxt;
  BTUpdate                 r_out;
  logic [15:0]             r_drop_cnt;

  logic [CW-1:0]           w_push_cnt;
  logic [CW-1:0]           w_drop_cnt;
  BTUpdate [NUM_PORTS-1:0] w_push_data;
  logic                    w_pop_req;
  logic                    w_pop_vld;
  BTUpdate                 w_pop_data;
  logic [AW:0]             w_free_cnt;
  BTUpdate                 w_newest;
  logic                    w_fifo_empty;
  logic                    w_issue;

  assign w_pop_req = (r_state == ST_ISSUE) && !bus.IN_flush;

  bt_update_fifo #(
    .DEPTH     (QUEUE_DEPTH),
    .NUM_PORTS (NUM_PORTS)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_flush     (bus.IN_flush),
    .i_push_cnt  (w_push_cnt),
    .i_push_data (w_push_data),
    .i_pop       (w_pop_req),
    .o_pop_vld   (w_pop_vld),
    .o_pop_data  (w_pop_data),
    .o_free_cnt  (w_free_cnt),
    .o_newest    (w_newest),
    .o_empty     (w_fifo_empty)
  );

  // Dedup against the newest stored entry and lower ports, then compact in port order.
  always_comb begin : sel
    int   n_push;
    int   n_drop;
    logic keep;
    n_push      = 0;
    n_drop      = 0;
    keep        = 1'b0;
    w_push_data = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      keep = bus.IN_res[p].valid;
      if (keep && !bus.IN_res[p].clean) begin
        if (!w_fifo_empty && same_target(w_newest, bus.IN_res[p])) begin
          keep = 1'b0;
        end
        for (int q = 0; q < p; q++) begin
          if (bus.IN_res[q].valid && same_target(bus.IN_res[q], bus.IN_res[p])) begin
            keep = 1'b0;
          end
        end
      end
      if (keep) begin
        if (n_push < int'(w_free_cnt)) begin
          w_push_data[n_push] = bus.IN_res[p];
          n_push++;
        end else begin
          n_drop++;
        end
      end
    end
    if (rst || bus.IN_flush) begin
      n_push = 0;
      n_drop = 0;
    end
    w_push_cnt = CW'(n_push);
    w_drop_cnt = CW'(n_drop);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    case (r_state)
      ST_ISSUE: begin
        w_issue = w_pop_vld;
        if (w_issue && w_pop_data.multiple) begin
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: w_state_nxt = ST_ISSUE;
      default: w_state_nxt = ST_ISSUE;
    endcase
    if (bus.IN_flush) begin
      w_state_nxt = ST_ISSUE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_ISSUE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Output register: only the valid bit is reset, payload is don't-care when idle.
  always_ff @(posedge clk) begin
    if (w_issue) begin
      r_out <= w_pop_data;
    end
    if (rst) begin
      r_out.valid <= 1'b0;
    end else begin
      r_out.valid <= w_issue;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_cnt <= '0;
    end else begin
      r_drop_cnt <= sat_add16(r_drop_cnt, w_drop_cnt);
    end
  end

  assign bus.OUT_btUpdate = r_out;
  assign bus.OUT_dropCnt  = r_drop_cnt;
  assign bus.OUT_empty    = w_fifo_empty;

endmodule

// File: tb/tb_bt_update_queue.sv
// Directed bench for bt_update_queue with a cycle-level reference queue used as scoreboard.
module tb_bt_update_queue;
  import bt_update_queue_pkg::*;

  localparam int DEPTH = 8;
  localparam int NP    = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bt_update_queue_if #(.NUM_PORTS(NP)) ifc ();

  bt_update_queue #(
    .QUEUE_DEPTH (DEPTH),
    .NUM_PORTS   (NP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  int      n_chk  = 0;
  int      n_pass = 0;
  int      n_fail = 0;
  BTUpdate sb_q[$];
  bit      m_hold;
  int      m_drop;
  bit      m_exp_vld;
  BTUpdate m_exp;
  int      n_out;
  logic [31:0] vhist;
  string   cur;
  BTUpdate idle;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic BTUpdate mk(input logic [31:0] src, input logic [31:0] dst,
                                 input bit mult, input bit clean);
    BTUpdate u;
    u.valid          = 1'b1;
    u.clean          = clean;
    u.multiple       = mult;
    u.fetchStartOffs = src[2:0];
    u.src            = src;
    u.dst            = dst;
    return u;
  endfunction

  function automatic bit tgt_eq(input BTUpdate a, input BTUpdate b);
    return (a.src == b.src) && (a.dst == b.dst) && (a.multiple == b.multiple);
  endfunction

  // Reference behaviour for one clock: accept, dedup, drop, then issue or bubble.
  task automatic model_cycle(input BTUpdate [NP-1:0] r, input bit fl);
    bit      pop_ok;
    int      sz;
    int      free;
    int      drops;
    bit      dup;
    BTUpdate newest;
    if (fl) begin
      sb_q.delete();
      m_hold    = 1'b0;
      m_exp_vld = 1'b0;
      return;
    end
    pop_ok = !m_hold;
    sz     = sb_q.size();
    free   = DEPTH - sz + ((pop_ok && sz > 0) ? 1 : 0);
    drops  = 0;
    newest = '0;
    if (sz > 0) newest = sb_q[sz-1];
    for (int p = 0; p < NP; p++) begin
      if (r[p].valid) begin
        dup = 1'b0;
        if (!r[p].clean) begin
          if (sz > 0 && tgt_eq(newest, r[p])) dup = 1'b1;
          for (int q = 0; q < p; q++)
            if (r[q].valid && tgt_eq(r[q], r[p])) dup = 1'b1;
        end
        if (!dup) begin
          if (free > 0) begin
            sb_q.push_back(r[p]);
            free--;
          end else begin
            drops++;
          end
        end
      end
    end
    m_drop = (m_drop + drops > 65535) ? 65535 : m_drop + drops;
    if (pop_ok && sb_q.size() > 0) begin
      m_exp     = sb_q.pop_front();
      m_exp_vld = 1'b1;
      m_hold    = m_exp.multiple;
    end else begin
      m_exp_vld = 1'b0;
      m_hold    = 1'b0;
    end
  endtask

  task automatic step(input BTUpdate r0, input BTUpdate r1, input bit fl);
    BTUpdate [NP-1:0] r;
    r[0] = r0;
    r[1] = r1;
    ifc.IN_res   = r;
    ifc.IN_flush = fl;
    model_cycle(r, fl);
    @(posedge clk);
    #1;
    chk({cur, "_vld"}, 64'(ifc.OUT_btUpdate.valid), 64'(m_exp_vld));
    if (m_exp_vld) begin
      chk({cur, "_src"}, 64'(ifc.OUT_btUpdate.src), 64'(m_exp.src));
      chk({cur, "_dst"}, 64'(ifc.OUT_btUpdate.dst), 64'(m_exp.dst));
      chk({cur, "_mul"}, 64'(ifc.OUT_btUpdate.multiple), 64'(m_exp.multiple));
    end
    chk({cur, "_drop"}, 64'(ifc.OUT_dropCnt), 64'(m_drop));
    chk({cur, "_empty"}, 64'(ifc.OUT_empty), 64'(sb_q.size() == 0));
    if (ifc.OUT_btUpdate.valid === 1'b1) n_out++;
    vhist        = {vhist[30:0], ifc.OUT_btUpdate.valid};
    ifc.IN_res   = '0;
    ifc.IN_flush = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    rst          = 1'b1;
    ifc.IN_res   = '0;
    ifc.IN_flush = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    sb_q.delete();
    m_hold = 1'b0;
    m_drop = 0;
    chk({cur, "_rst_vld"}, 64'(ifc.OUT_btUpdate.valid), 64'd0);
    chk({cur, "_rst_drop"}, 64'(ifc.OUT_dropCnt), 64'd0);
    chk({cur, "_rst_empty"}, 64'(ifc.OUT_empty), 64'd1);
    rst = 1'b0;
  endtask

  initial begin
    idle         = '0;
    ifc.IN_res   = '0;
    ifc.IN_flush = 1'b0;
    m_hold       = 1'b0;
    m_drop       = 0;
    vhist        = '0;

    cur = "init";
    do_reset(2);

    // Two ports in one cycle leave in port order on consecutive cycles.
    cur = "order";
    step(mk(32'h1000, 32'hA000, 0, 0), mk(32'h2000, 32'hB000, 0, 0), 0);
    chk("order_c1_src", 64'(ifc.OUT_btUpdate.src), 64'h1000);
    step(idle, idle, 0);
    chk("order_c2_src", 64'(ifc.OUT_btUpdate.src), 64'h2000);
    step(idle, idle, 0);

    // Multiple-bit update forces one idle cycle.
    cur = "bubble";
    step(mk(32'h3000, 32'hC000, 1, 0), mk(32'h3100, 32'hC100, 0, 0), 0);
    step(mk(32'h3200, 32'hC200, 0, 0), idle, 0);
    step(idle, idle, 0);
    step(idle, idle, 0);
    chk("bubble_pattern", 64'(vhist[3:0]), 64'b1011);
    step(idle, idle, 0);

    cur = "dedup_ports";
    n_out = 0;
    step(mk(32'h4000, 32'hD000, 0, 0), mk(32'h4000, 32'hD000, 0, 0), 0);
    step(idle, idle, 0);
    step(idle, idle, 0);
    chk("dedup_ports_cnt", 64'(n_out), 64'd1);

    cur = "clean_ports";
    n_out = 0;
    step(mk(32'h4000, 32'hD000, 0, 1), mk(32'h4000, 32'hD000, 0, 1), 0);
    step(idle, idle, 0);
    step(idle, idle, 0);
    chk("clean_ports_cnt", 64'(n_out), 64'd2);

    cur = "dedup_newest";
    n_out = 0;
    step(mk(32'h5000, 32'hE000, 1, 0), mk(32'h5100, 32'hE100, 0, 0), 0);
    step(mk(32'h5100, 32'hE100, 0, 0), idle, 0);
    step(idle, idle, 0);
    step(idle, idle, 0);
    chk("dedup_newest_cnt", 64'(n_out), 64'd2);

    // Saturate the queue with multiple-bit updates so dequeue runs at half rate.
    cur = "fill";
    for (int i = 0; i < 7; i++)
      step(mk(32'h6000 + 32'(2*i), 32'hF000, 1, 0), mk(32'h6001 + 32'(2*i), 32'hF000, 1, 0), 0);
    chk("fill_drop", 64'(ifc.OUT_dropCnt), 64'd2);
    cur = "drain";
    n_out = 0;
    for (int i = 0; i < 18; i++) step(idle, idle, 0);
    chk("drain_cnt", 64'(n_out), 64'd8);

    cur = "flush";
    for (int i = 0; i < 5; i++)
      step(mk(32'h7000 + 32'(2*i), 32'h1, 0, 0), mk(32'h7001 + 32'(2*i), 32'h1, 0, 0), 0);
    chk("flush_pre_empty", 64'(ifc.OUT_empty), 64'd0);
    step(mk(32'h7100, 32'h1, 0, 0), mk(32'h7101, 32'h1, 0, 0), 1);
    chk("flush_vld", 64'(ifc.OUT_btUpdate.valid), 64'd0);
    chk("flush_empty", 64'(ifc.OUT_empty), 64'd1);
    chk("flush_drop", 64'(ifc.OUT_dropCnt), 64'd2);
    step(idle, idle, 0);

    cur = "wrap";
    for (int i = 0; i < 20; i++)
      step(mk(32'h8000 + 32'(i), 32'h2, 0, 0),
           (i % 3 == 0) ? mk(32'h8800 + 32'(i), 32'h2, 0, 0) : idle, 0);
    for (int i = 0; i < 10; i++) step(idle, idle, 0);
    chk("wrap_drop", 64'(ifc.OUT_dropCnt), 64'd2);
    chk("wrap_empty", 64'(ifc.OUT_empty), 64'd1);

    // Reset while an entry is queued and a bubble is pending.
    cur = "midrst";
    step(mk(32'h9000, 32'h3, 1, 0), mk(32'h9100, 32'h3, 0, 0), 0);
    do_reset(1);
    step(mk(32'h9200, 32'h3, 0, 0), idle, 0);
    chk("midrst_next_src", 64'(ifc.OUT_btUpdate.src), 64'h9200);
    step(idle, idle, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bt_update_queue.md
BT_UPDATE_QUEUE -- requirements
Module: bt_update_queue

Interface
REQ-001 Parameter QUEUE_DEPTH, default 8, power of two, number of buffered BTB updates.
REQ-002 Parameter NUM_PORTS, default 2, number of branch-resolution input ports.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 IN_res  input  NUM_PORTS x BTUpdate  resolved-branch update requests, each with its own valid bit.
REQ-006 IN_flush  input  1  discard all queued and incoming updates this cycle.
REQ-007 OUT_btUpdate  output  BTUpdate  registered update to the branch target buffer; at most one per cycle.
REQ-008 OUT_dropCnt  output  16  saturating count of updates lost to a full queue.
REQ-009 OUT_empty  output  1  high when the queue holds no entries.

Function
REQ-010 Storage SHALL be a circular FIFO of QUEUE_DEPTH BTUpdate entries with log2(QUEUE_DEPTH)+1-bit read and write pointers; full when the pointers differ only in the MSB.
REQ-011 Each cycle, valid IN_res ports SHALL enqueue in ascending port order, up to the free space available at the start of the cycle.
REQ-012 A valid port that finds no free slot SHALL be dropped, and OUT_dropCnt SHALL increment by the number dropped, saturating at 0xFFFF.
REQ-013 Dedup: an incoming non-clean request whose src, dst and multiple match the newest queued entry, or a lower-numbered port's request in the same cycle, SHALL be discarded without counting as a drop.
REQ-014 A clean request SHALL never be deduplicated.
REQ-015 Dequeue SHALL pop the oldest entry into the OUT_btUpdate register; an entry enqueued in cycle N appears on OUT_btUpdate no earlier than cycle N+1.
REQ-016 OUT_btUpdate.valid SHALL be 0 in any cycle with nothing to issue; the other fields are then don't-care.
REQ-017 Multiple-bubble rule: after a cycle in which OUT_btUpdate.valid=1 and multiple=1, the next cycle SHALL issue OUT_btUpdate.valid=0, because the target buffer commits its deferred multiple-bit write only in an idle update cycle.
REQ-018 Bubble control SHALL be a two-state FSM: ISSUE -> HOLD when a multiple=1 update is issued; HOLD -> ISSUE unconditionally after one cycle.
REQ-019 A simultaneous enqueue and dequeue when full SHALL free the dequeued slot first, so one enqueue succeeds in the same cycle.
REQ-020 Pointer wrap-around SHALL be modulo 2*QUEUE_DEPTH with no loss of entries.
REQ-021 IN_flush SHALL in the same edge reset both pointers, drop that cycle's inputs without counting them, force OUT_btUpdate.valid=0 and the FSM to ISSUE.
REQ-022 OUT_dropCnt SHALL be unaffected by IN_flush.
REQ-023 OUT_empty SHALL be combinational from the pointers and SHALL exclude the entry held in the output register.

Reset
REQ-024 On rst, pointers SHALL be 0, FSM ISSUE, OUT_btUpdate.valid 0, OUT_dropCnt 0, OUT_empty 1.
REQ-025 Queue storage SHALL NOT be reset.
REQ-026 rst asserted mid-operation SHALL discard all queued entries and any pending bubble in the same edge.

Structure
REQ-027 BTUpdate, FetchOff_t and the default QUEUE_DEPTH constant SHALL come from the shared core package; no new typedefs are local to this module.
REQ-028 One sub-module, bt_update_fifo, SHALL hold the storage and pointers.
REQ-029 bt_update_fifo SHALL expose push count, pop and free count.
REQ-030 Dedup, drop counting, the FSM and the output register SHALL stay in bt_update_queue.

Verification
REQ-031 Port0 src=0x1000 and port1 src=0x2000 valid in cycle 0 -> OUT_btUpdate shows 0x1000 in cycle 1 and 0x2000 in cycle 2.
REQ-032 Issue an update with multiple=1 followed by two queued updates -> valid pattern 1,0,1,1.
REQ-033 Fill 8 entries with no dequeue possible, then 2 more valid inputs -> OUT_dropCnt=2 and the first 8 entries drain in order.
REQ-034 The same non-clean src/dst sent on port0 and port1 -> exactly one output.
REQ-035 The same request sent as clean on both ports -> two outputs.
REQ-036 IN_flush with 5 entries queued -> next cycle OUT_btUpdate.valid=0, OUT_empty=1, OUT_dropCnt unchanged.
REQ-037 Drive 20 enqueue/dequeue cycles across the pointer wrap -> output order equals input order and no drops.
